// File: rtl/stack_ctrl_pkg.sv
// rtl/stack_ctrl_pkg.sv - shared widths and FSM state encodings for the stack controller
package stack_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int RAM_W  = 9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_CAP  = 2'd3;

endpackage

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - LIFO controller driving an external synchronous single-port RAM
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int               DEPTH = 8,
    parameter logic [ADDR_W-1:0] BASE  = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic              ready,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [7:0]        count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [RAM_W-1:0]  ram_dout
);

    localparam logic [7:0] DEPTH_C = DEPTH[7:0];

    logic [1:0]        state_q,     state_d;
    logic [7:0]        count_q,     count_d;
    logic [DATA_W-1:0] pop_data_q,  pop_data_d;
    logic              pop_valid_q, pop_valid_d;
    logic              overflow_q,  overflow_d;
    logic              underflow_q, underflow_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_din_q,   ram_din_d;
    logic              ram_we_q,    ram_we_d;

    // Bit 8 of the RAM word carries nothing for this controller.
    logic unused_ram_bit8;
    assign unused_ram_bit8 = ram_dout[8];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_we_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Push wins over a simultaneous pop; the pop is dropped.
                if (push) begin
                    if (count_q < DEPTH_C) begin
                        state_d    = ST_WR;
                        ram_we_d   = 1'b1;
                        ram_addr_d = BASE + count_q;
                        ram_din_d  = push_data;
                        count_d    = count_q + 8'd1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (pop) begin
                    if (count_q != 8'd0) begin
                        state_d    = ST_RD;
                        ram_addr_d = BASE + count_q - 8'd1;
                        count_d    = count_q - 8'd1;
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
            end
            ST_WR:  state_d = ST_IDLE;
            ST_RD:  state_d = ST_CAP;
            ST_CAP: begin
                state_d     = ST_IDLE;
                pop_data_d  = ram_dout[DATA_W-1:0];
                pop_valid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= 8'd0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            ram_addr_q  <= BASE;
            ram_din_q   <= '0;
            ram_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_we_q    <= ram_we_d;
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == 8'd0);
    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_we    = ram_we_q;

endmodule
